// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a registered read. The read response is routed back to its owner.
// Define RAM_ARBITER_ROUND_ROBIN_EN to get round-robin with burst lock; otherwise requester 0 always wins.
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_we,
  input  logic [1:0]              req_lock,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [DATA_WIDTH-1:0]   ram_data,
  output logic [ADDR_WIDTH-1:0]   ram_write_addr,
  output logic [ADDR_WIDTH-1:0]   ram_read_addr,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_q
);

  logic [1:0]            w_grant;
  logic                  w_any;
  logic                  w_sel;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_addr;

  // Stage p0: combinational arbitration
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
  logic r_ptr;
  logic r_lock_vld;
  logic r_lock_own;
  logic w_lock_act;

  always_comb begin
    w_grant    = 2'b00;
    w_lock_act = r_lock_vld && req_valid[r_lock_own];
    if (reset) begin
      w_grant = 2'b00;
    end else if (w_lock_act) begin
      w_grant[r_lock_own] = 1'b1;
    end else if (req_valid == 2'b11) begin
      w_grant[r_ptr] = 1'b1;
    end else begin
      w_grant = req_valid;
    end
  end

  // A lock dropped by its holder while the other side is idle stays pending, so an idle bus never disturbs state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr      <= 1'b0;
      r_lock_vld <= 1'b0;
      r_lock_own <= 1'b0;
    end else if (w_any) begin
      r_ptr      <= ~w_sel;
      r_lock_vld <= req_lock[w_sel];
      r_lock_own <= w_sel;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = ^req_lock;

  always_comb begin
    w_grant = 2'b00;
    if (!reset) begin
      if (req_valid[0]) begin
        w_grant = 2'b01;
      end else if (req_valid[1]) begin
        w_grant = 2'b10;
      end
    end
  end
`endif

  assign w_any     = |w_grant;
  assign w_sel     = w_grant[1];
  assign w_rd_acc  = w_any && !req_we[w_sel];
  assign req_ready = w_grant;

  assign w_addr         = w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign ram_read_addr  = w_addr;
  assign ram_write_addr = w_addr;
  assign ram_data       = w_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  assign ram_we         = w_any && req_we[w_sel];

  // Stage p1: RAM read data returns; owner bit steers rsp_valid
  logic r_rd_vld_p1;
  logic r_owner_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_vld_p1 <= 1'b0;
      r_owner_p1  <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd_acc;
      if (w_rd_acc) begin
        r_owner_p1 <= w_sel;
      end
    end
  end

  // Gated by reset so a read accepted just before reset never reports.
  assign rsp_valid = (r_rd_vld_p1 && !reset) ? (r_owner_p1 ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data  = ram_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width of all data paths.
REQ-002 Parameter ADDR_WIDTH, default 6, SHALL set the word-address width of all address paths.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on posedge clock.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 req_valid  in  2  SHALL carry the per-requester request strobes; bit i belongs to requester i.
REQ-006 req_we  in  2  SHALL be the per-requester write flags; 1 = write, 0 = read.
REQ-007 req_lock  in  2  SHALL be the per-requester burst lock; 1 = keep grant after this access.
REQ-008 req_addr  in  2*ADDR_WIDTH  SHALL carry the word addresses; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 req_wdata  in  2*DATA_WIDTH  SHALL carry the write data; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  out  2  SHALL be the one-hot accept signal; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
REQ-011 rsp_valid  out  2  SHALL be the one-hot read-data-valid indication.
REQ-012 rsp_data  out  DATA_WIDTH  SHALL carry the read data, qualified by rsp_valid.
REQ-013 ram_data  out  DATA_WIDTH  SHALL drive the RAM write data.
REQ-014 ram_write_addr  out  ADDR_WIDTH  SHALL drive the RAM write address.
REQ-015 ram_read_addr  out  ADDR_WIDTH  SHALL drive the RAM read address.
REQ-016 ram_we  out  1  SHALL drive the RAM write enable.
REQ-017 ram_q  in  DATA_WIDTH  SHALL receive the RAM registered read data (1-cycle latency, same clock).

Function
REQ-018 At most one access SHALL be accepted per cycle; req_ready SHALL be combinational from req_valid, the priority pointer and the lock state, and SHALL be 0 for a requester whose req_valid is 0.
REQ-019 With a single requester valid, that requester SHALL be granted in the same cycle.
REQ-020 With both valid and no lock held, the requester selected by the priority pointer (ptr) SHALL be granted.
REQ-021 After each accepted access by requester i with req_lock[i]=0, ptr SHALL become 1-i.
REQ-022 On an accepted access by requester i with req_lock[i]=1, the lock SHALL be held by i and only i may be granted until i completes an accepted access with req_lock[i]=0 or deasserts req_valid[i] for one cycle.
REQ-023 A granted requester's address SHALL drive both ram_read_addr and ram_write_addr, and its req_wdata SHALL drive ram_data; ram_we SHALL equal the granted req_we and SHALL be 0 when nothing is granted.
REQ-024 For an accepted read in cycle N, rsp_valid for that requester SHALL be 1 in cycle N+1 with rsp_data = ram_q, and 0 otherwise; writes SHALL produce no rsp_valid.
REQ-025 Back-to-back reads from different requesters SHALL each return their responses in consecutive cycles to the correct owner, tracked by a registered owner bit.
REQ-026 A write accepted in cycle N followed by a read of the same address accepted in cycle N+1 SHALL return the new data.
REQ-027 With no requester valid, ptr and the lock state SHALL hold their values.

Reset
REQ-028 While reset=1: req_ready=0, ram_we=0, rsp_valid=0, ptr=0, lock released, owner=0; rsp_data SHALL follow ram_q.
REQ-029 A read accepted in the cycle before reset asserts SHALL NOT produce rsp_valid during reset; operation SHALL resume on the first cycle after reset deasserts.

Configuration
REQ-030 Macro RAM_ARBITER_ROUND_ROBIN_EN defined: ptr and lock SHALL behave as in REQ-020..022.
REQ-031 Macro RAM_ARBITER_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins; ptr logic and the req_lock function SHALL be removed, and req_lock SHALL be ignored.

Verification
REQ-032 Reset, then requester 0 writes 0xDEADBEEF to address 5, then reads address 5 in the next cycle -> rsp_valid=2'b01 one cycle after the read accept, rsp_data=0xDEADBEEF.
REQ-033 Both requesters hold reads continuously with lock=0 (RR enabled) -> grants alternate 0,1,0,1; each rsp_valid bit pulses in the cycle after its own grant.
REQ-034 Requester 1 issues 3 locked reads and a final unlocked read while requester 0 stays valid -> four consecutive grants to requester 1, then requester 0 is granted.
REQ-035 Read accepted in cycle N, reset asserted in cycle N+1 -> rsp_valid=0 in cycle N+1, and all outputs equal their reset values.
REQ-036 Macro undefined, both requesters valid for 4 cycles -> requester 0 is granted in all 4 cycles and requester 1 receives no grant.
